// File: rtl/branch_cond_unit.sv
// Flag register plus B / B.cond / CBZ / CBNZ evaluation; registered take-branch decision.
// Flags set in the same cycle are forwarded into the condition check.
module branch_cond_unit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic             br_valid,
    input  logic [1:0]       br_type,
    input  logic [3:0]       cond,
    input  logic [WIDTH-1:0] cb_operand,
    output logic [3:0]       flags_q,
    output logic             take_branch,
    output logic             br_done
);

    localparam logic [1:0] BR_B    = 2'b00;
    localparam logic [1:0] BR_COND = 2'b01;
    localparam logic [1:0] BR_CBZ  = 2'b10;
    localparam logic [1:0] BR_CBNZ = 2'b11;

    // f is {N,Z,C,V}
    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        case (c)
            4'h0:    cond_holds = z;
            4'h1:    cond_holds = !z;
            4'h2:    cond_holds = cy;
            4'h3:    cond_holds = !cy;
            4'h4:    cond_holds = n;
            4'h5:    cond_holds = !n;
            4'h6:    cond_holds = v;
            4'h7:    cond_holds = !v;
            4'h8:    cond_holds = cy & !z;
            4'h9:    cond_holds = !cy | z;
            4'hA:    cond_holds = (n == v);
            4'hB:    cond_holds = (n != v);
            4'hC:    cond_holds = !z & (n == v);
            4'hD:    cond_holds = z | (n != v);
            default: cond_holds = 1'b1;
        endcase
    endfunction

    logic [3:0] new_flags_p0;
    logic [3:0] eff_flags_p0;
    logic       decision_p0;
    logic       cb_zero_p0;

    always_comb begin
        new_flags_p0 = {alu_result[WIDTH-1], ~|alu_result, alu_carry, alu_overflow};
        eff_flags_p0 = set_flags ? new_flags_p0 : flags_q;
        cb_zero_p0   = ~|cb_operand;
        decision_p0  = 1'b0;
        case (br_type)
            BR_B:    decision_p0 = 1'b1;
            BR_COND: decision_p0 = cond_holds(cond, eff_flags_p0);
            BR_CBZ:  decision_p0 = cb_zero_p0;
            BR_CBNZ: decision_p0 = !cb_zero_p0;
            default: decision_p0 = 1'b0;
        endcase
    end

    // Stage p0 -> p1: flag register and branch decision register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q     <= 4'b0000;
            take_branch <= 1'b0;
            br_done     <= 1'b0;
        end else if (en) begin
            if (set_flags)
                flags_q <= new_flags_p0;
            take_branch <= br_valid & decision_p0;
            br_done     <= br_valid;
        end
    end

endmodule
